shake256_msg_feeder: RTL and testbench

- Transmit end of the SHAKE256 core's bit-serial message interface.
- Accepts message bytes from a host valid/ready stream and shifts them LSB-first onto the core's serial input.
- Signals end-of-message, pulses the core's start, waits for done, then captures and holds the 512-bit digest for the host.
- Sits between the host/bus adapter and the SHAKE256 core.

---
 rtl/shake256_msg_feeder_if.sv | 13 +
 rtl/shake256_msg_feeder.sv | 138 +++++++++++++
 tb/tb_shake256_msg_feeder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shake256_msg_feeder_if.sv
// Host-side byte stream into the SHAKE256 message feeder.
// The host drives data beats; the feeder answers with in_ready.
`timescale 1ns/1ps
interface shake256_msg_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_zero;

  modport master (output in_valid, in_data, in_last, in_zero, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_zero, output in_ready);
endinterface

// File: rtl/shake256_msg_feeder.sv
// Serialises host message bytes LSB-first into the SHAKE256 core, sequences
// end/start, then waits for done and holds the captured 512-bit digest.
`timescale 1ns/1ps
module shake256_msg_feeder #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  shake256_msg_feeder_if.slave host,
  output logic                 ser_enable,
  output logic                 ser_data,
  output logic                 ser_end,
  output logic                 ser_start,
  input  logic                 ser_done,
  input  logic [511:0]         ser_digest,
  output logic [511:0]         digest_out,
  output logic                 digest_valid,
  output logic [CNT_W-1:0]     msg_bits,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STALL,
    ST_END,
    ST_START,
    ST_WAIT_DONE
  } state_t;

  state_t            state;
  logic [7:0]        byte_q;
  logic              last_q;
  logic [2:0]        bit_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_slot;

  // A new beat may be taken on the final bit of a non-last byte or while stalled.
  assign load_slot     = (state == ST_STALL) ||
                         (state == ST_SHIFT && bit_idx == 3'd7 && !last_q);
  assign host.in_ready = !reset && (state == ST_IDLE || load_slot);
  assign ser_enable    = (state == ST_SHIFT);
  assign ser_data      = ser_enable & byte_q[bit_idx];
  assign ser_end       = (state == ST_END) || (state == ST_START) || (state == ST_WAIT_DONE);
  assign ser_start     = (state == ST_START);
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_q       <= '0;
      last_q       <= 1'b0;
      bit_idx      <= '0;
      wait_cnt     <= '0;
      msg_bits     <= '0;
      digest_out   <= '0;
      digest_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (host.in_valid) begin
            msg_bits    <= '0;
            timeout_err <= 1'b0;
            if (host.in_zero) begin
              if (host.in_last) state <= ST_END;
            end else begin
              byte_q  <= host.in_data;
              last_q  <= host.in_last;
              bit_idx <= '0;
              state   <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          if (msg_bits != '1) msg_bits <= msg_bits + CNT_W'(1);
          bit_idx <= bit_idx + 3'd1;
          // bit_idx wraps to 0 by itself, so a byte loaded here follows gaplessly.
          if (bit_idx == 3'd7) begin
            if (last_q) begin
              state <= ST_END;
            end else if (!host.in_valid) begin
              state <= ST_STALL;
            end else if (host.in_zero) begin
              state <= host.in_last ? ST_END : ST_STALL;
            end else begin
              byte_q <= host.in_data;
              last_q <= host.in_last;
            end
          end
        end

        ST_STALL: begin
          if (host.in_valid) begin
            if (host.in_zero) begin
              if (host.in_last) state <= ST_END;
            end else begin
              byte_q  <= host.in_data;
              last_q  <= host.in_last;
              bit_idx <= '0;
              state   <= ST_SHIFT;
            end
          end
        end

        ST_END: state <= ST_START;

        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_DONE;
        end

        // Done is checked before the timeout so a coincident done still captures.
        ST_WAIT_DONE: begin
          if (ser_done) begin
            digest_out   <= ser_digest;
            digest_valid <= 1'b1;
            state        <= ST_IDLE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake256_msg_feeder.sv
// Self-checking bench: a message-level model (expected bit queue, start/done
// timing, digest) is compared against the feeder every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_shake256_msg_feeder;
  localparam int TO = 16;
  localparam logic [511:0] EMPTY_DIGEST =
    512'h46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762fd75dc4ddd8c0f200cb05019d67b592f6fc821c49479ab48640292eacb3b7c4be;

  logic         clk = 1'b0;
  logic         reset;
  logic         ser_enable, ser_data, ser_end, ser_start, ser_done;
  logic [511:0] ser_digest, digest_out;
  logic         digest_valid, busy, timeout_err;
  logic [31:0]  msg_bits;

  shake256_msg_feeder_if host();

  shake256_msg_feeder #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .host(host),
    .ser_enable(ser_enable), .ser_data(ser_data), .ser_end(ser_end),
    .ser_start(ser_start), .ser_done(ser_done), .ser_digest(ser_digest),
    .digest_out(digest_out), .digest_valid(digest_valid), .msg_bits(msg_bits),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the serial side must carry and when start/done must land.
  bit           exp_bits[$];
  int           exp_msg_bits = 0;
  int           exp_start_cnt = -1;
  int           exp_stalls = 0;
  int           stall_cycles = 0;
  int           en_cycles = 0;
  int           exp_dv_cnt = -1;
  int           stub_fire_cnt = -1;
  int           done_delay = 3;
  bit           core_mute = 1'b0;
  bit           idle_poke = 1'b0;
  bit           msg_open = 1'b0;
  bit           check_en = 1'b0;
  logic [511:0] exp_digest = '0;
  logic [511:0] pending_digest = '0;
  logic [511:0] stub_val = '0;
  logic [63:0]  obs_seq = '0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic modelAccept(input logic [7:0] d, input bit last, input bit zero);
    if (!msg_open) begin
      exp_msg_bits = 0;
      stall_cycles = 0;
      en_cycles    = 0;
      obs_seq      = '0;
    end
    if (!zero) begin
      msg_open = 1'b1;
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      exp_msg_bits += 8;
    end
    if (last) begin
      exp_start_cnt = cycle + (zero ? 2 : 10);
      msg_open      = 1'b0;
    end
  endtask

  // Called on a negedge; returns on the negedge after the beat was taken.
  task automatic applyStimulus(input logic [7:0] d, input bit last, input bit zero, output int acc_cnt);
    int budget;
    bit acc;
    budget  = 0;
    acc     = 1'b0;
    acc_cnt = -1;
    host.in_valid = 1'b1;
    host.in_data  = d;
    host.in_last  = last;
    host.in_zero  = zero;
    while (!acc && budget < 200) begin
      #1;
      if (host.in_ready) begin
        acc     = 1'b1;
        acc_cnt = cycle;
        modelAccept(d, last, zero);
      end
      @(negedge clk);
      budget++;
    end
    if (!acc) checkOutput("accept_timeout", host.in_ready, 1);
    host.in_valid = 1'b0;
    host.in_last  = 1'b0;
    host.in_zero  = 1'b0;
  endtask

  task automatic finishMsg(input int k);
    int budget;
    budget = 0;
    while (cycle < exp_start_cnt + k + 1 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("busy_after_msg", busy, 0);
    checkOutput("ser_end_after_msg", ser_end, 0);
    @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("rst_ser_enable", ser_enable, 0);
    checkOutput("rst_ser_data", ser_data, 0);
    checkOutput("rst_ser_end", ser_end, 0);
    checkOutput("rst_ser_start", ser_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_msg_bits", msg_bits, 0);
    checkOutput("rst_digest_out", digest_out, 0);
    checkOutput("rst_digest_valid", digest_valid, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_in_ready", host.in_ready, 0);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      if (cycle == exp_dv_cnt) exp_digest = pending_digest;
      if (ser_enable) begin
        en_cycles++;
        obs_seq = {obs_seq[62:0], ser_data};
        if (exp_bits.size() == 0) checkOutput("ser_enable_unexpected", ser_enable, 0);
        else checkOutput("ser_data", ser_data, exp_bits.pop_front());
      end else begin
        checkOutput("ser_data_quiet", ser_data, 0);
      end
      if (busy && !ser_enable && !ser_end) stall_cycles++;
      checkOutput("ser_start", ser_start, cycle == exp_start_cnt);
      if (cycle == exp_start_cnt) begin
        checkOutput("msg_bits_at_start", msg_bits, exp_msg_bits);
        checkOutput("bits_left_at_start", exp_bits.size(), 0);
        checkOutput("stalls_at_start", stall_cycles, exp_stalls);
        checkOutput("ser_end_at_start", ser_end, 1);
        if (!core_mute) begin
          stub_fire_cnt  = cycle + done_delay;
          exp_dv_cnt     = cycle + done_delay + 1;
          pending_digest = stub_val;
        end
      end
      checkOutput("digest_valid", digest_valid, cycle == exp_dv_cnt);
      checkOutput("digest_out", digest_out, exp_digest);
    end
  end

  // Core stub: raises done for one cycle, done_delay cycles after start.
  initial begin
    ser_done   = 1'b0;
    ser_digest = '0;
    forever begin
      @(negedge clk);
      #2;
      ser_done   = (cycle == stub_fire_cnt) || idle_poke;
      ser_digest = idle_poke ? {16{32'hDEADBEEF}} : (ser_done ? pending_digest : '0);
    end
  end

  initial begin
    int a0, a1, a2, s;
    int budget;
    reset         = 1'b1;
    host.in_valid = 1'b0;
    host.in_data  = '0;
    host.in_last  = 1'b0;
    host.in_zero  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;
    #1;
    checkOutput("in_ready_idle", host.in_ready, 1);
    check_en = 1'b1;
    @(negedge clk);

    $display("[TB] zero-length message");
    stub_val = EMPTY_DIGEST;
    applyStimulus(8'h00, 1'b1, 1'b1, a0);
    checkOutput("zl_ser_end_next", ser_end, 1);
    checkOutput("zl_no_start_yet", ser_start, 0);
    finishMsg(done_delay);
    checkOutput("zl_digest_top", digest_out[511:448], 64'h46b9dd2b0ba88d13);
    checkOutput("zl_msg_bits", msg_bits, 0);
    checkOutput("zl_enables", en_cycles, 0);

    $display("[TB] single byte A5");
    stub_val = {8{64'h00000000000000A5}};
    applyStimulus(8'hA5, 1'b1, 1'b0, a0);
    finishMsg(done_delay);
    checkOutput("a5_bit_seq", obs_seq[7:0], 8'b10100101);
    checkOutput("a5_msg_bits", msg_bits, 8);
    checkOutput("a5_enables", en_cycles, 8);

    $display("[TB] three bytes gapless");
    stub_val = {16{32'h00018001}};
    applyStimulus(8'h01, 1'b0, 1'b0, a0);
    applyStimulus(8'h80, 1'b0, 1'b0, a1);
    applyStimulus(8'hFF, 1'b1, 1'b0, a2);
    checkOutput("b2_accept_gap", a1 - a0, 8);
    checkOutput("b3_accept_gap", a2 - a1, 8);
    finishMsg(done_delay);
    checkOutput("three_bit_seq", obs_seq[23:0], 24'h8001FF);
    checkOutput("three_msg_bits", msg_bits, 24);
    checkOutput("three_enables", en_cycles, 24);

    $display("[TB] host gap of five cycles");
    exp_stalls = 5;
    stub_val = {16{32'h3CC33CC3}};
    applyStimulus(8'h3C, 1'b0, 1'b0, a0);
    repeat (12) @(negedge clk);
    applyStimulus(8'hC3, 1'b1, 1'b0, a1);
    checkOutput("gap_accept_delta", a1 - a0, 13);
    finishMsg(done_delay);
    checkOutput("gap_enables", en_cycles, 16);
    checkOutput("gap_bit_seq", obs_seq[15:0], 16'h3CC3);

    $display("[TB] zero beat mid-message and dropped idle beat");
    exp_stalls = 1;
    stub_val = {16{32'h11002200}};
    applyStimulus(8'h11, 1'b0, 1'b0, a0);
    applyStimulus(8'h00, 1'b0, 1'b1, a1);
    applyStimulus(8'h22, 1'b1, 1'b0, a2);
    finishMsg(done_delay);
    checkOutput("zmid_msg_bits", msg_bits, 16);
    exp_stalls = 0;
    applyStimulus(8'h00, 1'b0, 1'b1, a0);
    checkOutput("drop_stays_idle", busy, 0);
    checkOutput("drop_clears_bits", msg_bits, 0);

    $display("[TB] done pulse while idle");
    idle_poke = 1'b1;
    @(negedge clk);
    idle_poke = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_done_ignored", digest_out, exp_digest);

    $display("[TB] timeout");
    core_mute = 1'b1;
    applyStimulus(8'h77, 1'b1, 1'b0, a0);
    s = exp_start_cnt;
    budget = 0;
    while (cycle < s + TO && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("to_last_wait_end", ser_end, 1);
    checkOutput("to_last_wait_busy", busy, 1);
    checkOutput("to_not_yet", timeout_err, 0);
    @(negedge clk);
    checkOutput("to_flag", timeout_err, 1);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_ser_end", ser_end, 0);
    checkOutput("to_digest_held", digest_out, exp_digest);
    core_mute = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("to_sticky", timeout_err, 1);

    $display("[TB] done coincident with timeout, flag clears");
    done_delay = TO;
    stub_val = {16{32'h0BADF00D}};
    applyStimulus(8'h01, 1'b1, 1'b0, a0);
    checkOutput("to_cleared_on_accept", timeout_err, 0);
    finishMsg(done_delay);
    checkOutput("tie_no_timeout", timeout_err, 0);
    done_delay = 3;

    $display("[TB] reset in the middle of a byte");
    stub_val = {16{32'h5A5A5A5A}};
    applyStimulus(8'h5A, 1'b1, 1'b0, a0);
    repeat (4) @(negedge clk);
    reset    = 1'b1;
    check_en = 1'b0;
    exp_bits.delete();
    exp_start_cnt = -1;
    exp_dv_cnt    = -1;
    stub_fire_cnt = -1;
    msg_open      = 1'b0;
    exp_digest    = '0;
    @(negedge clk);
    checkResetState();
    reset    = 1'b0;
    check_en = 1'b1;
    repeat (20) @(negedge clk);
    stub_val = {16{32'hE7E7E7E7}};
    applyStimulus(8'hE7, 1'b1, 1'b0, a0);
    finishMsg(done_delay);
    checkOutput("post_rst_msg_bits", msg_bits, 8);
    checkOutput("post_rst_digest", digest_out, {16{32'hE7E7E7E7}});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
